// File: rtl/out_buffer_drain_ctrl_pkg.sv
// Shared definitions for the output-buffer drain controller slice.
package out_buf_pkg;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_READ,
    ST_WAIT,
    ST_PRESENT,
    ST_DONE
  } drain_state_t;

  typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/out_buffer_drain_ctrl_if.sv
// Drained-word output stream towards the host read slave.
interface out_buffer_drain_ctrl_if
  import out_buf_pkg::*;
#(
  parameter int unsigned DATA_W = out_buf_pkg::DATA_W
);

  logic [DATA_W-1:0] out_data;
  ch_idx_t           out_ch;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_last,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/out_buffer_drain_ctrl_ptr.sv
// Per-channel RAM bookkeeping: write/read pointers, fill level, sticky overflow.
module out_buf_ptr
  import out_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = out_buf_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_adv,
  output logic              wr_acc,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   fill,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic full;

  // Accept a producer write only while there is room; held off during reset.
  always_comb begin
    full   = (fill == DEPTH);
    wr_acc = wr_en && !full && reset_n;
  end

  // Pointer, fill and overflow state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_adv})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/out_buffer_drain_ctrl.sv
// Output RAM drain controller: tracks per-channel fill from producer write
// strobes and, on start, streams each channel's snapshot in channel order.
module out_buffer_drain_ctrl
  import out_buf_pkg::*;
#(
  parameter int unsigned NUM_CH = out_buf_pkg::NUM_CH,
  parameter int unsigned ADDR_W = out_buf_pkg::ADDR_W,
  parameter int unsigned DATA_W = out_buf_pkg::DATA_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CH-1:0]              wr_en,
  output logic [NUM_CH-1:0]              ram_wren,
  output logic [NUM_CH-1:0][ADDR_W-1:0]  ram_wraddress,
  output logic [NUM_CH-1:0]              ram_rden,
  output logic [NUM_CH-1:0][ADDR_W-1:0]  ram_rdaddress,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ram_q,
  input  logic                           start,
  out_buffer_drain_ctrl_if.master        out_if,
  output logic [NUM_CH-1:0][ADDR_W:0]    fill,
  output logic [NUM_CH-1:0]              overflow,
  output logic                           busy,
  output logic                           done
);

  localparam logic [ADDR_W:0] REMAIN_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam ch_idx_t         LAST_CH    = ch_idx_t'(NUM_CH - 1);

  drain_state_t      state;
  ch_idx_t           ch;
  logic [ADDR_W:0]   remain;
  logic [NUM_CH-1:0] rd_adv;

  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t idx);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (idx == ch_idx_t'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    out_buf_ptr #(.ADDR_W(ADDR_W)) u_ptr (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_en[c]),
      .rd_adv   (rd_adv[c]),
      .wr_acc   (ram_wren[c]),
      .wr_ptr   (ram_wraddress[c]),
      .rd_ptr   (ram_rdaddress[c]),
      .fill     (fill[c]),
      .overflow (overflow[c])
    );
  end

  // Host acceptance of the presented word advances the selected channel.
  always_comb begin
    rd_adv = '0;
    if (state == ST_PRESENT && out_if.out_ready) rd_adv = ch_onehot(ch);
  end

  // Drain sequencer with registered stream, RAM read enable and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      ch               <= '0;
      remain           <= '0;
      ram_rden         <= '0;
      out_if.out_data  <= '0;
      out_if.out_ch    <= '0;
      out_if.out_last  <= 1'b0;
      out_if.out_valid <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_SEL;
            ch    <= '0;
            busy  <= 1'b1;
          end
        end
        // Snapshot fill so words written mid-pass wait for the next pass.
        ST_SEL: begin
          if (fill[ch] == '0) begin
            if (ch == LAST_CH) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              ch <= ch + 2'd1;
            end
          end else begin
            remain   <= fill[ch];
            ram_rden <= ch_onehot(ch);
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          ram_rden <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          out_if.out_data  <= ram_q[ch];
          out_if.out_ch    <= ch;
          out_if.out_last  <= (remain == REMAIN_ONE);
          out_if.out_valid <= 1'b1;
          state            <= ST_PRESENT;
        end
        // Last channel finishes straight into DONE instead of a dead SEL step.
        ST_PRESENT: begin
          if (out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
            remain           <= remain - 1'b1;
            if (remain == REMAIN_ONE) begin
              if (ch == LAST_CH) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                ch    <= ch + 2'd1;
                state <= ST_SEL;
              end
            end else begin
              ram_rden <= ch_onehot(ch);
              state    <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
